// File: rtl/regfile_writeback.sv
// Register-file writeback queue: merges load (mem) and ALU/FPU results into a
// single in-order register-file write port, and reports which read operands
// still have an uncommitted write in flight.

// Per-entry tag compare against the two read operands being decoded.
module wb_tag_match (
  input  logic       occ,
  input  logic [6:0] tag,
  input  logic [6:0] key1,
  input  logic [6:0] key2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = occ && (tag == key1);
  assign hit2 = occ && (tag == key2);
endmodule

module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [5:0]  mem_reg,
  input  logic [31:0] mem_data,
  input  logic        mem_float,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [5:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        alu_float,
  output logic        alu_ready,
  input  logic        wb_hold,
  output logic [5:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic        float,
  input  logic [5:0]  readReg1,
  input  logic [5:0]  readReg2,
  input  logic        read_float,
  output logic        pending1,
  output logic        pending2,
  output logic [4:0]  fifo_count
);
  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef struct packed {
    logic        fp;
    logic [5:0]  rg;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t         ent_q [DEPTH];
  wb_entry_t         ent_d [DEPTH];
  wb_entry_t         out_q, out_d;
  logic              rw_q, rw_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wp;
  logic [4:0]        count_q, count_d;
  logic              mem_push, alu_push, pop;

  // Readiness looks only at registered occupancy; a same-cycle pop earns no credit.
  assign mem_ready = count_q < DEPTH_C;
  assign alu_ready = (count_q <= DEPTH_C - 5'd2) ||
                     ((count_q == DEPTH_C - 5'd1) && !mem_valid);

  // Enqueue mem then alu (mem is older), drop $zero writes, pop head when not held.
  always_comb begin
    mem_push = mem_valid && mem_ready && (mem_float || (mem_reg != 6'd0));
    alu_push = alu_valid && alu_ready && (alu_float || (alu_reg != 6'd0));
    pop      = (count_q != 5'd0) && !wb_hold;
    ent_d    = ent_q;
    wp       = wr_ptr_q;
    if (mem_push) begin
      ent_d[wp] = '{fp: mem_float, rg: mem_reg, data: mem_data};
      wp        = wp + PW'(1);
    end
    if (alu_push) begin
      ent_d[wp] = '{fp: alu_float, rg: alu_reg, data: alu_data};
      wp        = wp + PW'(1);
    end
    wr_ptr_d = wp;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + 5'(mem_push) + 5'(alu_push) - 5'(pop);
    rw_d     = pop;
    out_d    = pop ? ent_q[rd_ptr_q] : out_q;
  end

  // Queue storage, pointers and the registered write port; reset drops everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      out_q    <= '0;
      rw_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      out_q    <= out_d;
      rw_q     <= rw_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign writeReg   = out_q.rg;
  assign writeData  = out_q.data;
  assign float      = out_q.fp;
  assign regWrite   = rw_q;
  assign fifo_count = count_q;

  // Hazard detection: every live queue slot plus the write port in flight.
  logic [6:0]       key1, key2;
  logic [DEPTH-1:0] hit1, hit2;
  assign key1 = {read_float, readReg1};
  assign key2 = {read_float, readReg2};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    localparam logic [PW-1:0] IDX = PW'(g);
    logic [PW-1:0] off;
    assign off = IDX - rd_ptr_q;
    wb_tag_match u_match (
      .occ  (5'(off) < count_q),
      .tag  ({ent_q[g].fp, ent_q[g].rg}),
      .key1 (key1),
      .key2 (key2),
      .hit1 (hit1[g]),
      .hit2 (hit2[g])
    );
  end

  assign pending1 = (key1 != 7'd0) &&
                    ((|hit1) || (rw_q && ({out_q.fp, out_q.rg} == key1)));
  assign pending2 = (key2 != 7'd0) &&
                    ((|hit2) || (rw_q && ({out_q.fp, out_q.rg} == key2)));
endmodule
